// File: rtl/osc_phase_counter.sv
// osc_phase_counter: note/octave to period lookup plus sample-rate phase counter feeding the divider
module osc_phase_counter #(
  parameter int unsigned SAMPLE_DIV = 250
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        en,
  input  logic [3:0]  note_sel,
  input  logic [1:0]  octave,
  output logic [15:0] count,
  output logic [15:0] divider,
  output logic        flag,
  output logic        wrap
);
  if (SAMPLE_DIV < 12 || SAMPLE_DIV > 65535) begin : g_bad_div
    $error("osc_phase_counter: SAMPLE_DIV must be within 12..65535");
  end
  localparam logic [15:0] LAST = 16'(SAMPLE_DIV - 1);
  logic [15:0] presc_q, count_q, count_d, div_q, div_d, base, target;
  logic        flag_q, wrap_q, wrap_d, rest_q, rest_d, tick, sel_rest;
  // base period at octave 2 for a 40 kHz sample rate; zero marks a rest code
  always_comb begin
    case (note_sel)
      4'd1:    base = 16'd612;
      4'd2:    base = 16'd577;
      4'd3:    base = 16'd545;
      4'd4:    base = 16'd514;
      4'd5:    base = 16'd485;
      4'd6:    base = 16'd458;
      4'd7:    base = 16'd432;
      4'd8:    base = 16'd408;
      4'd9:    base = 16'd385;
      4'd10:   base = 16'd364;
      4'd11:   base = 16'd343;
      4'd12:   base = 16'd324;
      default: base = 16'd0;
    endcase
  end
  assign sel_rest = base == 16'd0;
  assign target   = sel_rest ? 16'd1 : base >> octave;
  assign tick     = en && presc_q == LAST;
  // next phase state at a tick; a new note is only accepted at a wrap or from silence
  always_comb begin
    count_d = count_q + 16'd1;
    div_d   = div_q;
    wrap_d  = 1'b0;
    rest_d  = rest_q;
    if (rest_q || count_q == div_q - 16'd1) begin
      count_d = 16'd0;
      div_d   = target;
      wrap_d  = !(rest_q && sel_rest);
      rest_d  = sel_rest;
    end
  end
  // prescaler, phase counter and registered strobes; disable parks everything at silence
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      presc_q <= 16'd0;
      count_q <= 16'd0;
      div_q   <= 16'd1;
      flag_q  <= 1'b0;
      wrap_q  <= 1'b0;
      rest_q  <= 1'b1;
    end else if (!en) begin
      presc_q <= 16'd0;
      count_q <= 16'd0;
      div_q   <= 16'd1;
      flag_q  <= 1'b0;
      wrap_q  <= 1'b0;
      rest_q  <= 1'b1;
    end else begin
      presc_q <= tick ? 16'd0 : presc_q + 16'd1;
      flag_q  <= tick;
      wrap_q  <= tick && wrap_d;
      if (tick) begin
        count_q <= count_d;
        div_q   <= div_d;
        rest_q  <= rest_d;
      end
    end
  end
  assign count   = count_q;
  assign divider = div_q;
  assign flag    = flag_q;
  assign wrap    = wrap_q;
endmodule

// File: tb/tb_osc_phase_counter.sv
// tb_osc_phase_counter: directed checks of period lookup, phase walk, note switching, enable and reset
module tb_osc_phase_counter;
  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  note_sel = 4'd0;
  logic [1:0]  octave = 2'd0;
  logic [15:0] count, divider;
  logic        flag, wrap;
  int errors = 0;
  int checks = 0;

  osc_phase_counter #(.SAMPLE_DIV(16)) dut (
    .clk(clk), .n_rst(n_rst), .en(en), .note_sel(note_sel), .octave(octave),
    .count(count), .divider(divider), .flag(flag), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // waits at negedges for the next flag; returns number of negedges waited, 0 on timeout
  task automatic to_flag(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (flag) begin
        n = i;
        return;
      end
    end
    check("flag_timeout", 0, 1);
  endtask

  // advances flag by flag until count equals c
  task automatic run_to(input logic [15:0] c);
    int n;
    for (int i = 0; i < 1000; i++) begin
      to_flag(n);
      if (n == 0) return;
      if (count == c) return;
    end
    check("run_to_timeout", 0, 1);
  endtask

  initial begin
    int n, nflags, bad;
    // 1: reset and idle with en low
    repeat (3) @(negedge clk);
    check("rst_count", count, 0);
    check("rst_div", divider, 1);
    check("rst_flag", flag, 0);
    check("rst_wrap", wrap, 0);
    n_rst = 1'b1;
    nflags = 0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (flag) nflags++;
      if (count != 0 || divider != 1 || wrap) bad++;
    end
    check("idle_flags", nflags, 0);
    check("idle_outputs", bad, 0);
    // 2: A at octave 2
    note_sel = 4'd10;
    en = 1'b1;
    to_flag(n);
    check("first_flag_lat", n, 16);
    check("a_count0", count, 0);
    check("a_div", divider, 364);
    check("a_wrap0", wrap, 1);
    @(negedge clk);
    check("flag_one_cycle", flag, 0);
    bad = 0;
    for (int i = 1; i <= 363; i++) begin
      to_flag(n);
      if (i == 1) check("flag_period", n, 15);
      if (count != i[15:0] || wrap || divider != 364) bad++;
    end
    check("a_walk", bad, 0);
    // 3: octave change mid-period takes effect at the wrap
    octave = 2'd2;
    to_flag(n);
    check("a_wrap_count", count, 0);
    check("a_wrap_div", divider, 91);
    check("a_wrap_pulse", wrap, 1);
    bad = 0;
    for (int i = 1; i <= 91; i++) begin
      to_flag(n);
      if (count != 16'(i % 91) || divider != 91) bad++;
      if ((32'(count) * 256) / 32'(divider) > 255) bad++;
      if (wrap != (i == 91)) bad++;
    end
    check("oct2_walk_phase", bad, 0);
    // 4: switch A to C mid-period
    octave = 2'd0;
    run_to(16'd0);
    check("back_a_div", divider, 364);
    run_to(16'd100);
    note_sel = 4'd1;
    run_to(16'd363);
    check("c_pending_div", divider, 364);
    to_flag(n);
    check("c_count", count, 0);
    check("c_div", divider, 612);
    check("c_wrap", wrap, 1);
    // 5: rest requested mid-period, then a note from silence
    note_sel = 4'd10;
    run_to(16'd0);
    check("a2_div", divider, 364);
    run_to(16'd50);
    note_sel = 4'd0;
    run_to(16'd363);
    check("rest_pending_div", divider, 364);
    to_flag(n);
    check("rest_enter_count", count, 0);
    check("rest_enter_div", divider, 1);
    check("rest_enter_wrap", wrap, 1);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      to_flag(n);
      if (count != 0 || divider != 1 || wrap) bad++;
    end
    check("rest_hold", bad, 0);
    note_sel = 4'd5;
    to_flag(n);
    check("e_count", count, 0);
    check("e_div", divider, 485);
    check("e_wrap", wrap, 1);
    // 6: drop enable mid-period
    note_sel = 4'd10;
    run_to(16'd0);
    run_to(16'd200);
    check("pre_dis_div", divider, 364);
    en = 1'b0;
    @(negedge clk);
    check("dis_count", count, 0);
    check("dis_div", divider, 1);
    nflags = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (flag || wrap) nflags++;
    end
    check("dis_no_flags", nflags, 0);
    en = 1'b1;
    to_flag(n);
    check("reen_lat", n, 16);
    check("reen_wrap", wrap, 1);
    check("reen_div", divider, 364);
    check("reen_count", count, 0);
    // 7: asynchronous reset mid-period, asserted during the flag cycle
    run_to(16'd10);
    #2 n_rst = 1'b0;
    #1;
    check("arst_flag", flag, 0);
    check("arst_count", count, 0);
    check("arst_div", divider, 1);
    check("arst_wrap", wrap, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/osc_phase_counter.md
Name: osc_phase_counter

Overview:
Upstream oscillator stage of the synth voice path, feeding sequential_div.
- Turns a note/octave selection into a 16-bit period (samples per waveform cycle).
- Runs a sample-rate phase counter that walks 0..period-1.
- Emits count, divider and a one-cycle flag per sample, so the divider computes the 8-bit phase (count*256/period) each sample.

Parameters:
SAMPLE_DIV, 250, clk cycles per sample tick (10 MHz / 250 = 40 kHz); legal range 12..65535, smaller values are an elaboration error.

Ports:
clk  in  1  system clock
n_rst  in  1  reset, asynchronous, active-low
en  in  1  voice enable; low holds phase at zero and suppresses flags
note_sel  in  4  1..12 = C..B; 0 and 13..15 = rest
octave  in  2  right-shift applied to base period (0 = octave 2, 3 = octave 5)
count  out  16  phase position within the current period
divider  out  16  active period in samples
flag  out  1  one-cycle sample strobe; count/divider valid in that cycle
wrap  out  1  one-cycle pulse coincident with flag when count restarts at 0

Behaviour:
- Reset (async): prescaler=0, count=0, divider=1, flag=0, wrap=0, active note = rest.
- Base period ROM (octave 0, 40 kHz), by note_sel 1..12: 612, 577, 545, 514, 485, 458, 432, 408, 385, 364, 343, 324.
- Target period = base >> octave.
- Rest and invalid codes give target period 1 and force count=0.
- Prescaler: 16-bit, counts 0..SAMPLE_DIV-1 while en=1.
- The tick is the cycle in which the prescaler equals SAMPLE_DIV-1; the prescaler wraps to 0 on the following edge.
- On the tick edge, count, divider, flag and wrap update together, all registered. flag=1 for exactly the one cycle after the tick; all other cycles flag=0. Latency from tick to flag is 1 cycle.
- Tick with a non-rest active note:
  - If count == divider-1: count<=0, wrap<=1, and the note/octave sampled this cycle is loaded (divider <= target period).
  - Otherwise: count<=count+1, wrap<=0, divider unchanged.
- Tick with a rest active note:
  - If the sampled note is non-rest: count<=0, divider<=target, wrap<=1 (immediate start from silence).
  - Otherwise: count<=0, divider<=1, wrap<=0.
- Note or octave changes only take effect at a wrap (click-free). Changes between wraps are not queued; the value sampled at the wrapping tick is the one used.
- Rest requested mid-period: the current period finishes, then count=0 and divider=1 from the next tick on.
- Invariant: count < divider, so the downstream quotient fits 8 bits and divider is never 0.
- count and divider are stable for at least SAMPLE_DIV-1 cycles after each flag. This covers the downstream load + 8 divide cycles.
- en=0:
  - On the next edge: prescaler<=0, count<=0, flag<=0, wrap<=0, active note <= rest, divider<=1.
  - Re-enable restarts the prescaler from 0; the first flag comes SAMPLE_DIV cycles after en rises.
- Reset mid-operation returns everything to reset values immediately; flag drops asynchronously.

Test Plan:
1. SAMPLE_DIV=16. Hold n_rst=0, then release, en=0 → count=0, divider=1, flag=0, wrap=0 throughout; no flag for 100 cycles.
2. en=1, note_sel=10, octave=0 → first flag 16 cycles after en rises, with count=0, divider=364, wrap=1. Flags every 16 cycles; count 1,2,…,363 then 0 with wrap=1.
3. note_sel=10, octave=2 → divider=91; count runs 0..90 and wraps. Check the 8-bit downstream phase stays ≤255.
4. Switch A→C (note_sel 10→1) at count=100 → divider stays 364 until count 363. Next flag gives count=0, divider=612, wrap=1.
5. note_sel=0 at count=50 of A → counts continue to 363. Then count=0, divider=1, wrap=0 on every following flag. Returning to note_sel=5 → next flag gives divider=485, count=0, wrap=1 immediately.
6. Drop en at count=200, then raise it 5 cycles later → count=0, divider=1 on the next edge with no flags while low. The first flag comes 16 cycles after re-enable, with wrap=1.
7. Assert n_rst mid-period → flag drops immediately and outputs return to reset values.
